hart_retire_monitor: RTL and testbench
======================================

Name: hart_retire_monitor

Overview:
- Synthesizable run-control and performance monitor attached to the hart retire interface.
- Replaces ad-hoc bench loops that count cycles and retires, detect halt, enforce a timeout and report CPI inputs.
- Generalised to NUM_RETIRE retire lanes (for future multi-issue harts), configurable counter width and a configurable timeout.
- Sits beside the hart; readable by benches and by on-chip debug logic.

Parameters:
- NUM_RETIRE, 1, retire lanes per cycle; lane 0 is the oldest instruction.
- CNT_WIDTH, 32, width of every event counter.
- TIMEOUT, 40000, cycle budget; the run aborts when cycles exceeds this value.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse; IDLE->RUN.
- i_clear  in  1  synchronous return to IDLE; zeroes counters and flags.
- i_retire_valid  in  NUM_RETIRE  per-lane retire valid.
- i_retire_halt  in  NUM_RETIRE  per-lane halt.
- i_retire_trap  in  NUM_RETIRE  per-lane trap.
- i_retire_dmem_ren  in  NUM_RETIRE  per-lane load.
- i_retire_dmem_wen  in  NUM_RETIRE  per-lane store.
- i_retire_pc  in  32*NUM_RETIRE  per-lane pc, lane k at bits [32k+31:32k].
- i_retire_next_pc  in  32*NUM_RETIRE  per-lane next_pc, same packing.
- o_state  out  2  0=IDLE, 1=RUN, 2=HALTED, 3=TIMEOUT.
- o_done  out  1  high in HALTED or TIMEOUT.
- o_cycles  out  CNT_WIDTH  cycles spent in RUN.
- o_instret  out  CNT_WIDTH  retired instructions.
- o_loads  out  CNT_WIDTH  retired loads.
- o_stores  out  CNT_WIDTH  retired stores.
- o_traps  out  CNT_WIDTH  retired traps.
- o_halt_pc  out  32  pc of the halting instruction.
- o_order_err  out  1  pc continuity error (optional feature only).
- o_err_pc  out  32  pc that broke continuity (optional feature only).

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all counters, o_halt_pc, o_order_err and o_err_pc = 0; o_done=0.
- IDLE:
  - Counters hold; retire inputs are ignored.
  - i_start moves to RUN on the next edge. The start cycle itself is not counted.
- RUN, every edge:
  - cycles += 1.
  - Per lane k: the lane is effective if valid[k] and no lower lane j<k has valid[j]&halt[j]. Lanes younger than a halting lane are dropped.
  - instret += popcount(effective).
  - loads, stores and traps += popcount(effective & respective flag).
- Halt: if any effective lane has halt, capture the lowest such lane's pc into o_halt_pc, include that lane in the counts, and go to HALTED.
- Timeout: if no halt and the updated cycles equals TIMEOUT+1, go to TIMEOUT.
- Halt and timeout on the same cycle: HALTED wins.
- HALTED and TIMEOUT are terminal. Counters hold. i_start is ignored; only i_clear or reset leaves them.
- i_clear has priority over i_start and retire events. It forces IDLE and zeroes everything on the next edge.
- Counters saturate at all-ones and never wrap.
- All outputs are registered. Count updates are visible the cycle after the retire edge.
- Reset asserted mid-RUN: immediate IDLE with zeroed outputs.
- Lanes are independent. Non-contiguous valid patterns (e.g. 4'b0101) are legal.

Optional Feature:
- Macro: HART_MON_ORDER_CHECK_EN.
- Defined:
  - Keeps an expected-pc register, loaded from the first effective lane's pc after start.
  - Each effective lane's pc must equal the expected pc. The expected pc then advances to that lane's next_pc, chained lane-by-lane within a cycle.
  - The first mismatch sets o_order_err (sticky until clear/reset) and captures o_err_pc. Later mismatches do not overwrite it.
- Undefined: the check logic is absent; o_order_err and o_err_pc are tied to 0.

Test Plan:
1. NUM_RETIRE=1. Start, then retire 10 valid instructions on consecutive cycles, the 10th with halt and pc=0x24 -> state=2, o_instret=10, o_cycles=10, o_halt_pc=0x00000024, o_done=1.
2. TIMEOUT=100, no retires after start -> TIMEOUT state with o_cycles=101 and o_instret=0. A valid+halt arriving after that -> no change.
3. NUM_RETIRE=4. Valid=4'b1111 with halt=4'b0010, lane1 pc=0x40; lane2 has a load -> o_instret=2, o_loads=0, o_halt_pc=0x40, HALTED.
4. Mixed lanes: valid=4'b1011, dmem_ren=4'b0001, dmem_wen=4'b1000, trap=4'b0010 -> instret +3, loads +1, stores +1, traps +1.
5. CNT_WIDTH=4. 20 single retires -> o_instret holds at 15. Then i_clear -> all counters 0, IDLE. Clear and start asserted together -> IDLE.
6. With HART_MON_ORDER_CHECK_EN: retire pcs 0x0, 0x4, 0xC with next_pc = pc+4 -> o_order_err=1, o_err_pc=0x0000000C. Without the macro -> o_order_err=0.

Source files
------------

// File: rtl/hart_retire_monitor.sv
// hart_retire_monitor
// -------------------
// Run-control and performance monitor that sits beside a hart's retire port.
// It counts the cycles spent running and the retired instructions, loads,
// stores and traps. It also detects halt, enforces a cycle budget and keeps
// the pc of the halting instruction. All outputs come from flops.
//
// Optional build macro: HART_MON_ORDER_CHECK_EN
//   When defined, each effective retire pc is checked against the next_pc of
//   the previous effective retire. When undefined, o_order_err and o_err_pc
//   are tied to 0.
//
// Parameters
//   NUM_RETIRE  retire lanes per cycle (lane 0 = oldest)
//   CNT_WIDTH   width of every event counter (saturating)
//   TIMEOUT     cycle budget; the run aborts once cycles reaches TIMEOUT+1
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               one-cycle pulse, IDLE -> RUN
//   i_clear               synchronous return to IDLE, zeroes counters/flags
//   i_retire_*            per-lane retire bundle (pc/next_pc: lane k at [32k+31:32k])
//   o_state               0=IDLE 1=RUN 2=HALTED 3=TIMEOUT (FSM state, debug visible)
//   o_done                high in HALTED or TIMEOUT
//   o_cycles .. o_traps   event counters
//   o_halt_pc             pc of the halting instruction
//   o_order_err, o_err_pc first pc continuity error and its pc
module hart_retire_monitor #(
  parameter int NUM_RETIRE = 1,
  parameter int CNT_WIDTH  = 32,
  parameter int TIMEOUT    = 40000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_clear,
  input  logic [NUM_RETIRE-1:0]    i_retire_valid,
  input  logic [NUM_RETIRE-1:0]    i_retire_halt,
  input  logic [NUM_RETIRE-1:0]    i_retire_trap,
  input  logic [NUM_RETIRE-1:0]    i_retire_dmem_ren,
  input  logic [NUM_RETIRE-1:0]    i_retire_dmem_wen,
  input  logic [32*NUM_RETIRE-1:0] i_retire_pc,
  input  logic [32*NUM_RETIRE-1:0] i_retire_next_pc,
  output logic [1:0]               o_state,
  output logic                     o_done,
  output logic [CNT_WIDTH-1:0]     o_cycles,
  output logic [CNT_WIDTH-1:0]     o_instret,
  output logic [CNT_WIDTH-1:0]     o_loads,
  output logic [CNT_WIDTH-1:0]     o_stores,
  output logic [CNT_WIDTH-1:0]     o_traps,
  output logic [31:0]              o_halt_pc,
  output logic                     o_order_err,
  output logic [31:0]              o_err_pc
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  // Compared in 64 bits so a narrow counter that saturates below the limit
  // simply never times out instead of aliasing onto a truncated limit.
  localparam logic [63:0] TIMEOUT_LIMIT = 64'(TIMEOUT) + 64'd1;

  state_t               state_q, state_d;
  logic                 done_q, done_d;
  logic [CNT_WIDTH-1:0] cycles_q, cycles_d, cycles_inc;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic [CNT_WIDTH-1:0] loads_q, loads_d;
  logic [CNT_WIDTH-1:0] stores_q, stores_d;
  logic [CNT_WIDTH-1:0] traps_q, traps_d;
  logic [31:0]          halt_pc_q, halt_pc_d;

  logic [NUM_RETIRE-1:0] effective;
  logic                  halt_seen;
  logic [31:0]           halt_lane_pc;

  // Adds the number of set lanes to a counter, clamping at all-ones.
  function automatic logic [CNT_WIDTH-1:0] sat_add(
    input logic [CNT_WIDTH-1:0]  base,
    input logic [NUM_RETIRE-1:0] lanes
  );
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, base};
    for (int k = 0; k < NUM_RETIRE; k++) begin
      sum = sum + (CNT_WIDTH+1)'(lanes[k]);
    end
    return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
  endfunction

  assign cycles_inc = (&cycles_q) ? cycles_q
                                  : cycles_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // A lane counts only if no older lane halted in the same cycle. The halting
  // lane itself still counts and supplies the halt pc.
  always_comb begin
    effective    = '0;
    halt_seen    = 1'b0;
    halt_lane_pc = '0;
    for (int k = 0; k < NUM_RETIRE; k++) begin
      if (i_retire_valid[k] && !halt_seen) begin
        effective[k] = 1'b1;
        if (i_retire_halt[k]) begin
          halt_seen    = 1'b1;
          halt_lane_pc = i_retire_pc[32*k +: 32];
        end
      end
    end
  end

  // Next-state and counter update. i_clear overrides everything else.
  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    cycles_d  = cycles_q;
    instret_d = instret_q;
    loads_d   = loads_q;
    stores_d  = stores_q;
    traps_d   = traps_q;
    halt_pc_d = halt_pc_q;
    if (i_clear) begin
      state_d   = ST_IDLE;
      done_d    = 1'b0;
      cycles_d  = '0;
      instret_d = '0;
      loads_d   = '0;
      stores_d  = '0;
      traps_d   = '0;
      halt_pc_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) state_d = ST_RUN;
        end
        ST_RUN: begin
          cycles_d  = cycles_inc;
          instret_d = sat_add(instret_q, effective);
          loads_d   = sat_add(loads_q, effective & i_retire_dmem_ren);
          stores_d  = sat_add(stores_q, effective & i_retire_dmem_wen);
          traps_d   = sat_add(traps_q, effective & i_retire_trap);
          // Halt wins over a timeout landing on the same edge.
          if (halt_seen) begin
            state_d   = ST_HALTED;
            done_d    = 1'b1;
            halt_pc_d = halt_lane_pc;
          end else if (64'(cycles_inc) == TIMEOUT_LIMIT) begin
            state_d = ST_TIMEOUT;
            done_d  = 1'b1;
          end
        end
        default: ; // HALTED / TIMEOUT are terminal until clear or reset
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      cycles_q  <= '0;
      instret_q <= '0;
      loads_q   <= '0;
      stores_q  <= '0;
      traps_q   <= '0;
      halt_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      cycles_q  <= cycles_d;
      instret_q <= instret_d;
      loads_q   <= loads_d;
      stores_q  <= stores_d;
      traps_q   <= traps_d;
      halt_pc_q <= halt_pc_d;
    end
  end

  assign o_state   = state_q;
  assign o_done    = done_q;
  assign o_cycles  = cycles_q;
  assign o_instret = instret_q;
  assign o_loads   = loads_q;
  assign o_stores  = stores_q;
  assign o_traps   = traps_q;
  assign o_halt_pc = halt_pc_q;

`ifdef HART_MON_ORDER_CHECK_EN
  logic        exp_valid_q, exp_valid_d;
  logic [31:0] exp_pc_q, exp_pc_d;
  logic        order_err_q, order_err_d;
  logic [31:0] err_pc_q, err_pc_d;

  // The expected pc is chained lane by lane. The first effective lane after
  // start has nothing to compare against, so it only seeds the chain.
  always_comb begin
    exp_valid_d = exp_valid_q;
    exp_pc_d    = exp_pc_q;
    order_err_d = order_err_q;
    err_pc_d    = err_pc_q;
    if (i_clear) begin
      exp_valid_d = 1'b0;
      exp_pc_d    = '0;
      order_err_d = 1'b0;
      err_pc_d    = '0;
    end else if (state_q == ST_IDLE && i_start) begin
      exp_valid_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      for (int k = 0; k < NUM_RETIRE; k++) begin
        if (effective[k]) begin
          if (exp_valid_d && !order_err_d &&
              i_retire_pc[32*k +: 32] != exp_pc_d) begin
            order_err_d = 1'b1;
            err_pc_d    = i_retire_pc[32*k +: 32];
          end
          exp_valid_d = 1'b1;
          exp_pc_d    = i_retire_next_pc[32*k +: 32];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      exp_valid_q <= 1'b0;
      exp_pc_q    <= '0;
      order_err_q <= 1'b0;
      err_pc_q    <= '0;
    end else begin
      exp_valid_q <= exp_valid_d;
      exp_pc_q    <= exp_pc_d;
      order_err_q <= order_err_d;
      err_pc_q    <= err_pc_d;
    end
  end

  assign o_order_err = order_err_q;
  assign o_err_pc    = err_pc_q;
`else
  logic unused_next_pc;
  assign unused_next_pc = ^i_retire_next_pc;
  assign o_order_err    = 1'b0;
  assign o_err_pc       = '0;
`endif

endmodule

// File: tb/tb_hart_retire_monitor.sv
// Bench for hart_retire_monitor. It uses two instances: a 4-lane one with
// 32-bit counters and TIMEOUT=100, and a 1-lane one with 4-bit counters for
// saturation. Inputs change just after the falling edge and outputs are
// sampled at the next falling edge.
module tb_hart_retire_monitor;
  localparam int TO = 100;
  localparam longint WMAX = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // wide instance signals
  logic         w_start = 0, w_clear = 0;
  logic [3:0]   w_valid = 0, w_halt = 0, w_trap = 0, w_ren = 0, w_wen = 0;
  logic [127:0] w_pc = 0, w_npc = 0;
  logic [1:0]   w_state;
  logic         w_done, w_order_err;
  logic [31:0]  w_cycles, w_instret, w_loads, w_stores, w_traps, w_halt_pc, w_err_pc;

  // narrow instance signals
  logic        n_start = 0, n_clear = 0;
  logic [0:0]  n_valid = 0, n_halt = 0, n_trap = 0, n_ren = 0, n_wen = 0;
  logic [31:0] n_pc = 0, n_npc = 0;
  logic [1:0]  n_state;
  logic        n_done, n_order_err;
  logic [3:0]  n_cycles, n_instret, n_loads, n_stores, n_traps;
  logic [31:0] n_halt_pc, n_err_pc;

  hart_retire_monitor #(.NUM_RETIRE(4), .CNT_WIDTH(32), .TIMEOUT(TO)) u_wide (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(w_start), .i_clear(w_clear),
    .i_retire_valid(w_valid), .i_retire_halt(w_halt), .i_retire_trap(w_trap),
    .i_retire_dmem_ren(w_ren), .i_retire_dmem_wen(w_wen),
    .i_retire_pc(w_pc), .i_retire_next_pc(w_npc),
    .o_state(w_state), .o_done(w_done), .o_cycles(w_cycles), .o_instret(w_instret),
    .o_loads(w_loads), .o_stores(w_stores), .o_traps(w_traps),
    .o_halt_pc(w_halt_pc), .o_order_err(w_order_err), .o_err_pc(w_err_pc)
  );

  hart_retire_monitor #(.NUM_RETIRE(1), .CNT_WIDTH(4), .TIMEOUT(TO)) u_narrow (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(n_start), .i_clear(n_clear),
    .i_retire_valid(n_valid), .i_retire_halt(n_halt), .i_retire_trap(n_trap),
    .i_retire_dmem_ren(n_ren), .i_retire_dmem_wen(n_wen),
    .i_retire_pc(n_pc), .i_retire_next_pc(n_npc),
    .o_state(n_state), .o_done(n_done), .o_cycles(n_cycles), .o_instret(n_instret),
    .o_loads(n_loads), .o_stores(n_stores), .o_traps(n_traps),
    .o_halt_pc(n_halt_pc), .o_order_err(n_order_err), .o_err_pc(n_err_pc)
  );

  // ---------------- driver tasks ----------------
  task automatic wide_cycle(input logic start, input logic clear,
                            input logic [3:0] v, input logic [3:0] h,
                            input logic [3:0] t, input logic [3:0] r,
                            input logic [3:0] w,
                            input logic [127:0] pc, input logic [127:0] npc);
    w_start = start; w_clear = clear; w_valid = v; w_halt = h; w_trap = t;
    w_ren = r; w_wen = w; w_pc = pc; w_npc = npc;
    @(posedge clk);
    @(negedge clk);
    w_start = 0; w_clear = 0; w_valid = 0; w_halt = 0; w_trap = 0;
    w_ren = 0; w_wen = 0;
  endtask

  task automatic narrow_cycle(input logic start, input logic clear,
                              input logic v, input logic h, input logic [31:0] pc);
    n_start = start; n_clear = clear; n_valid = v; n_halt = h;
    n_pc = pc; n_npc = pc + 32'd4;
    @(posedge clk);
    @(negedge clk);
    n_start = 0; n_clear = 0; n_valid = 0; n_halt = 0;
  endtask

  // ---------------- reference model (wide instance) ----------------
  int          m_state;
  longint      m_cycles, m_instret, m_loads, m_stores, m_traps;
  logic [31:0] m_halt_pc, m_err_pc, m_exp_pc;
  bit          m_err, m_exp_valid;

  function automatic longint bump(input longint x, input longint maxv);
    return (x < maxv) ? x + 1 : maxv;
  endfunction

  task automatic model_step(input logic start, input logic clear,
                            input logic [3:0] v, input logic [3:0] h,
                            input logic [3:0] t, input logic [3:0] r,
                            input logic [3:0] w,
                            input logic [127:0] pc, input logic [127:0] npc);
    bit stopped;
    logic [31:0] lpc;
    if (clear) begin
      m_state = 0; m_cycles = 0; m_instret = 0; m_loads = 0; m_stores = 0;
      m_traps = 0; m_halt_pc = 0; m_err = 0; m_err_pc = 0;
      m_exp_valid = 0; m_exp_pc = 0;
    end else if (m_state == 0) begin
      if (start) begin
        m_state = 1;
        m_exp_valid = 0;
      end
    end else if (m_state == 1) begin
      m_cycles = bump(m_cycles, WMAX);
      stopped = 0;
      for (int k = 0; k < 4; k++) begin
        if (v[k] && !stopped) begin
          lpc = pc[32*k +: 32];
          m_instret = bump(m_instret, WMAX);
          if (r[k]) m_loads = bump(m_loads, WMAX);
          if (w[k]) m_stores = bump(m_stores, WMAX);
          if (t[k]) m_traps = bump(m_traps, WMAX);
          if (m_exp_valid && !m_err && lpc != m_exp_pc) begin
            m_err = 1;
            m_err_pc = lpc;
          end
          m_exp_valid = 1;
          m_exp_pc = npc[32*k +: 32];
          if (h[k]) begin
            stopped = 1;
            m_halt_pc = lpc;
          end
        end
      end
      if (stopped) m_state = 2;
      else if (m_cycles == TO + 1) m_state = 3;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++;
    if ({w_state, w_done, w_cycles, w_instret, w_loads, w_stores, w_traps,
         w_halt_pc, w_order_err, w_err_pc} !== '0) begin
      n_errors++;
      $display("FAIL reset_wide state=%0d done=%0d cyc=%0d inst=%0d hpc=%h err=%0d epc=%h (all should be 0)",
               w_state, w_done, w_cycles, w_instret, w_halt_pc, w_order_err, w_err_pc);
    end
    n_checks++;
    if ({n_state, n_done, n_cycles, n_instret, n_loads, n_stores, n_traps,
         n_halt_pc, n_order_err, n_err_pc} !== '0) begin
      n_errors++;
      $display("FAIL reset_narrow state=%0d done=%0d cyc=%0d inst=%0d (all should be 0)",
               n_state, n_done, n_cycles, n_instret);
    end
  endtask

  task automatic test_single_halt();
    narrow_cycle(0, 1, 0, 0, 0);
    narrow_cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) narrow_cycle(0, 0, 1, (i == 9), 32'(4 * i));
    n_checks++;
    if (n_state !== 2'd2 || n_done !== 1'b1) begin
      n_errors++;
      $display("FAIL halt_state got state=%0d done=%0d exp state=2 done=1", n_state, n_done);
    end
    n_checks++;
    if (n_instret !== 4'd10 || n_cycles !== 4'd10) begin
      n_errors++;
      $display("FAIL halt_counts got inst=%0d cyc=%0d exp 10/10", n_instret, n_cycles);
    end
    n_checks++;
    if (n_halt_pc !== 32'h24) begin
      n_errors++;
      $display("FAIL halt_pc got %h exp 00000024", n_halt_pc);
    end
  endtask

  task automatic test_timeout();
    wide_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
    wide_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO; i++) wide_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (w_state !== 2'd1 || w_cycles !== 32'(TO)) begin
      n_errors++;
      $display("FAIL timeout_edge got state=%0d cyc=%0d exp state=1 cyc=%0d", w_state, w_cycles, TO);
    end
    wide_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++;
    if (w_state !== 2'd3 || w_cycles !== 32'(TO + 1) || w_instret !== 0 || w_done !== 1'b1) begin
      n_errors++;
      $display("FAIL timeout_hit got state=%0d cyc=%0d inst=%0d done=%0d exp 3/%0d/0/1",
               w_state, w_cycles, w_instret, w_done, TO + 1);
    end
    wide_cycle(1, 0, 4'b0001, 4'b0001, 0, 0, 0, 128'h50, 128'h54);
    n_checks++;
    if (w_state !== 2'd3 || w_cycles !== 32'(TO + 1) || w_instret !== 0 || w_halt_pc !== 0) begin
      n_errors++;
      $display("FAIL timeout_hold got state=%0d cyc=%0d inst=%0d hpc=%h exp 3/%0d/0/0",
               w_state, w_cycles, w_instret, w_halt_pc, TO + 1);
    end
  endtask

  task automatic test_multi_lane_halt();
    wide_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
    wide_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    wide_cycle(0, 0, 4'b1111, 4'b0010, 0, 4'b0100, 0,
               {32'h48, 32'h44, 32'h40, 32'h3C}, {32'h4C, 32'h48, 32'h44, 32'h40});
    n_checks++;
    if (w_instret !== 32'd2 || w_loads !== 32'd0) begin
      n_errors++;
      $display("FAIL lane_halt_counts got inst=%0d loads=%0d exp 2/0", w_instret, w_loads);
    end
    n_checks++;
    if (w_halt_pc !== 32'h40 || w_state !== 2'd2) begin
      n_errors++;
      $display("FAIL lane_halt_pc got hpc=%h state=%0d exp 00000040/2", w_halt_pc, w_state);
    end
  endtask

  task automatic test_mixed_lanes();
    wide_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
    wide_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    wide_cycle(0, 0, 4'b1011, 4'b0000, 4'b0010, 4'b0001, 4'b1000,
               {32'h108, 32'h0, 32'h104, 32'h100}, {32'h10C, 32'h0, 32'h108, 32'h104});
    n_checks++;
    if (w_instret !== 32'd3 || w_loads !== 32'd1 || w_stores !== 32'd1 || w_traps !== 32'd1) begin
      n_errors++;
      $display("FAIL mixed_counts got inst=%0d ld=%0d st=%0d tr=%0d exp 3/1/1/1",
               w_instret, w_loads, w_stores, w_traps);
    end
    n_checks++;
    if (w_state !== 2'd1 || w_cycles !== 32'd1 || w_order_err !== 1'b0) begin
      n_errors++;
      $display("FAIL mixed_state got state=%0d cyc=%0d err=%0d exp 1/1/0", w_state, w_cycles, w_order_err);
    end
  endtask

  task automatic test_saturate_clear();
    narrow_cycle(0, 1, 0, 0, 0);
    narrow_cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) narrow_cycle(0, 0, 1, 0, 32'(4 * i));
    n_checks++;
    if (n_instret !== 4'd15 || n_cycles !== 4'd15 || n_state !== 2'd1) begin
      n_errors++;
      $display("FAIL saturate got inst=%0d cyc=%0d state=%0d exp 15/15/1", n_instret, n_cycles, n_state);
    end
    narrow_cycle(0, 1, 1, 1, 32'h80);
    n_checks++;
    if (n_state !== 2'd0 || n_instret !== 0 || n_cycles !== 0 || n_done !== 0 || n_halt_pc !== 0) begin
      n_errors++;
      $display("FAIL clear got state=%0d inst=%0d cyc=%0d done=%0d hpc=%h exp all 0",
               n_state, n_instret, n_cycles, n_done, n_halt_pc);
    end
    narrow_cycle(1, 1, 0, 0, 0);
    n_checks++;
    if (n_state !== 2'd0) begin
      n_errors++;
      $display("FAIL clear_over_start got state=%0d exp 0", n_state);
    end
  endtask

  task automatic test_order_check();
    logic        exp_err;
    logic [31:0] exp_pc;
`ifdef HART_MON_ORDER_CHECK_EN
    exp_err = 1'b1; exp_pc = 32'hC;
`else
    exp_err = 1'b0; exp_pc = 32'h0;
`endif
    wide_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
    wide_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    wide_cycle(0, 0, 4'b0001, 0, 0, 0, 0, 128'h0, 128'h4);
    wide_cycle(0, 0, 4'b0001, 0, 0, 0, 0, 128'h4, 128'h8);
    n_checks++;
    if (w_order_err !== 1'b0) begin
      n_errors++;
      $display("FAIL order_clean got err=%0d exp 0", w_order_err);
    end
    wide_cycle(0, 0, 4'b0001, 0, 0, 0, 0, 128'hC, 128'h10);
    n_checks++;
    if (w_order_err !== exp_err || w_err_pc !== exp_pc) begin
      n_errors++;
      $display("FAIL order_err got err=%0d pc=%h exp err=%0d pc=%h", w_order_err, w_err_pc, exp_err, exp_pc);
    end
    wide_cycle(0, 0, 4'b0001, 0, 0, 0, 0, 128'h50, 128'h54);
    n_checks++;
    if (w_order_err !== exp_err || w_err_pc !== exp_pc) begin
      n_errors++;
      $display("FAIL order_sticky got err=%0d pc=%h exp err=%0d pc=%h", w_order_err, w_err_pc, exp_err, exp_pc);
    end
  endtask

  task automatic test_mid_run_reset();
    wide_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
    wide_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) wide_cycle(0, 0, 4'b0001, 0, 0, 0, 0, 128'(4 * i), 128'(4 * i + 4));
    n_checks++;
    if (w_instret !== 32'd5 || w_state !== 2'd1) begin
      n_errors++;
      $display("FAIL prereset got inst=%0d state=%0d exp 5/1", w_instret, w_state);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (w_state !== 2'd0 || w_instret !== 0 || w_cycles !== 0 || w_done !== 0) begin
      n_errors++;
      $display("FAIL async_reset got state=%0d inst=%0d cyc=%0d done=%0d exp all 0",
               w_state, w_instret, w_cycles, w_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] cur;
    for (int run = 0; run < 8; run++) begin
      int len;
      len = $urandom_range(20, 130);
      cur = $urandom & 32'hFFFF_FFFC;
      for (int c = 0; c < len + 2; c++) begin
        logic st, cl;
        logic [3:0] v, h, t, r, w;
        logic [127:0] pc, npc;
        logic [31:0] p, n;
        cl = (c == 0);
        st = (c == 1) || ($urandom_range(0, 15) == 0);
        v = 4'($urandom);
        h = ($urandom_range(0, 39) == 0) ? 4'($urandom) : 4'b0;
        t = 4'($urandom) & 4'($urandom);
        r = 4'($urandom);
        w = 4'($urandom);
        for (int k = 0; k < 4; k++) begin
          p = ($urandom_range(0, 15) == 0) ? ($urandom & 32'hFFFF_FFFC) : cur;
          n = ($urandom_range(0, 15) == 0) ? ($urandom & 32'hFFFF_FFFC) : p + 32'd4;
          pc[32*k +: 32] = p;
          npc[32*k +: 32] = n;
          if (v[k]) cur = n;
        end
        model_step(st, cl, v, h, t, r, w, pc, npc);
        wide_cycle(st, cl, v, h, t, r, w, pc, npc);
`ifndef HART_MON_ORDER_CHECK_EN
        m_err = 0; m_err_pc = 0;
`endif
        n_checks++;
        if (w_state !== 2'(m_state) || w_done !== (m_state >= 2)) begin
          n_errors++;
          $display("FAIL rand_state run=%0d c=%0d got %0d/%0d exp %0d", run, c, w_state, w_done, m_state);
        end
        n_checks++;
        if (w_cycles !== 32'(m_cycles) || w_instret !== 32'(m_instret)) begin
          n_errors++;
          $display("FAIL rand_cyc_inst run=%0d c=%0d got %0d/%0d exp %0d/%0d",
                   run, c, w_cycles, w_instret, m_cycles, m_instret);
        end
        n_checks++;
        if (w_loads !== 32'(m_loads) || w_stores !== 32'(m_stores) || w_traps !== 32'(m_traps)) begin
          n_errors++;
          $display("FAIL rand_ldsttr run=%0d c=%0d got %0d/%0d/%0d exp %0d/%0d/%0d",
                   run, c, w_loads, w_stores, w_traps, m_loads, m_stores, m_traps);
        end
        n_checks++;
        if (w_halt_pc !== m_halt_pc) begin
          n_errors++;
          $display("FAIL rand_halt_pc run=%0d c=%0d got %h exp %h", run, c, w_halt_pc, m_halt_pc);
        end
        n_checks++;
        if (w_order_err !== m_err || w_err_pc !== m_err_pc) begin
          n_errors++;
          $display("FAIL rand_order run=%0d c=%0d got %0d/%h exp %0d/%h",
                   run, c, w_order_err, w_err_pc, m_err, m_err_pc);
        end
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_single_halt();
    test_timeout();
    test_multi_lane_halt();
    test_mixed_lanes();
    test_saturate_clear();
    test_order_check();
    test_mid_run_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
